// File: rtl/hqm_jg_clk_sched.sv
// Clock-generator schedule sequencer: steps a small table of {mode, freq, punch, dwell} entries,
// switching only on the generator's wrap boundary. Define HQM_JG_CLK_SCHED_LOOP_EN to repeat the table.
module hqm_jg_clk_sched #(
  parameter int WIDTH   = 4,
  parameter int DEPTH   = 8,
  parameter int DWELL_W = 8
) (
  input  logic                          reference_clk,
  input  logic                          reference_rst_n,
  input  logic                          cfg_we,
  input  logic [$clog2(DEPTH)-1:0]      cfg_addr,
  input  logic [2+2*WIDTH+DWELL_W-1:0]  cfg_wdata,
  input  logic                          start,
  input  logic                          stop,
  output logic [1:0]                    mode,
  output logic [WIDTH-1:0]              freq,
  output logic [WIDTH-1:0]              punch,
  output logic                          busy,
  output logic [$clog2(DEPTH)-1:0]      cur_idx,
  output logic                          done,
  output logic                          cfg_err
);

  // state | meaning
  // IDLE  | idle outputs applied, waiting for start
  // ALIGN | waiting for the generator boundary to apply entry[idx] or finish
  // DWELL | entry applied, dwell timer counting down

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 2 + 2*WIDTH + DWELL_W;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH-1);

`ifdef HQM_JG_CLK_SCHED_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    DWELL = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [EW-1:0]        tbl_q [DEPTH];
  logic [WIDTH-1:0]     cnt_q;
  logic [AW-1:0]        idx_q;
  logic [AW-1:0]        cur_idx_q;
  logic [DWELL_W-1:0]   dwell_q;
  logic                 end_q, end_d;
  logic [1:0]           mode_q;
  logic [WIDTH-1:0]     freq_q;
  logic [WIDTH-1:0]     punch_q;
  logic                 done_q;
  logic                 cfg_err_q;

  logic                 bnd;
  logic                 go_start, go_load, go_adv, go_idle;

  logic [EW-1:0]        ent;
  logic [1:0]           ent_mode;
  logic [WIDTH-1:0]     ent_freq;
  logic [WIDTH-1:0]     ent_punch;
  logic [DWELL_W-1:0]   ent_dwell;

  logic [1:0]           wr_mode;
  logic [WIDTH-1:0]     wr_freq;
  logic [WIDTH-1:0]     wr_punch;
  logic                 wr_bad;
  logic                 wr_ok;

  assign busy    = (state_q != IDLE);
  assign mode    = mode_q;
  assign freq    = freq_q;
  assign punch   = punch_q;
  assign cur_idx = cur_idx_q;
  assign done    = done_q;
  assign cfg_err = cfg_err_q;

  // Mirror of the generator's counter: changes are only safe where it wraps.
  assign bnd = (cnt_q == (freq_q - WIDTH'(1)));

  assign ent       = tbl_q[idx_q];
  assign ent_mode  = ent[EW-1 -: 2];
  assign ent_freq  = ent[EW-3 -: WIDTH];
  assign ent_punch = ent[DWELL_W+WIDTH-1 -: WIDTH];
  assign ent_dwell = ent[DWELL_W-1:0];

  assign wr_mode  = cfg_wdata[EW-1 -: 2];
  assign wr_freq  = cfg_wdata[EW-3 -: WIDTH];
  assign wr_punch = cfg_wdata[DWELL_W+WIDTH-1 -: WIDTH];
  assign wr_bad   = (wr_freq == '0) || ((wr_mode == 2'd2) && (wr_punch >= wr_freq));
  assign wr_ok    = cfg_we && !busy && !wr_bad;

  always_ff @(posedge reference_clk or negedge reference_rst_n) begin
    if (!reference_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_ok && (cfg_addr == AW'(i))) begin
          tbl_q[i] <= cfg_wdata;
        end
      end
    end
  end

  always_ff @(posedge reference_clk or negedge reference_rst_n) begin
    if (!reference_rst_n) begin
      state_q <= IDLE;
      end_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      end_q   <= end_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    end_d    = end_q;
    go_start = 1'b0;
    go_load  = 1'b0;
    go_adv   = 1'b0;
    go_idle  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          go_start = 1'b1;
          end_d    = 1'b0;
          state_d  = ALIGN;
        end
      end
      ALIGN: begin
        if (stop) end_d = 1'b1;
        if (bnd) begin
          if (end_q || stop || (ent_dwell == '0)) begin
            go_idle = 1'b1;
          end else begin
            go_load = 1'b1;
            // A one-cycle dwell is already spent by the load cycle itself.
            if (ent_dwell == DWELL_W'(1)) go_adv = 1'b1;
            else                          state_d = DWELL;
          end
        end
      end
      DWELL: begin
        if (stop) end_d = 1'b1;
        if ((end_q || stop) && bnd) go_idle = 1'b1;
        else if (dwell_q <= DWELL_W'(2)) go_adv = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (go_adv) begin
      state_d = ALIGN;
      if (!LOOP_EN && (idx_q == LAST_IDX)) end_d = 1'b1;
    end
    if (go_idle) begin
      state_d = IDLE;
      end_d   = 1'b0;
    end
  end

  always_ff @(posedge reference_clk or negedge reference_rst_n) begin
    if (!reference_rst_n) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      cur_idx_q <= '0;
      dwell_q   <= '0;
      mode_q    <= 2'd0;
      freq_q    <= WIDTH'(1);
      punch_q   <= '0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      cnt_q     <= bnd ? '0 : (cnt_q + WIDTH'(1));
      done_q    <= go_idle;
      cfg_err_q <= cfg_we && !wr_ok;

      if (go_start)    idx_q <= '0;
      else if (go_adv) idx_q <= idx_q + AW'(1);

      if (go_load) begin
        mode_q    <= ent_mode;
        freq_q    <= ent_freq;
        punch_q   <= ent_punch;
        cur_idx_q <= idx_q;
        dwell_q   <= ent_dwell;
      end else if (go_idle) begin
        mode_q    <= 2'd0;
        freq_q    <= WIDTH'(1);
        punch_q   <= '0;
        dwell_q   <= '0;
      end else if (state_q == DWELL) begin
        dwell_q   <= dwell_q - DWELL_W'(1);
      end
    end
  end

endmodule

// File: doc/hqm_jg_clk_sched.md
HQM_JG_CLK_SCHED -- requirements
Module: hqm_jg_clk_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 4, width of the generator frequency and punch fields.
REQ-002 SHALL have parameter DEPTH, default 8, number of schedule table entries (power of 2, at least 2).
REQ-003 SHALL have parameter DWELL_W, default 8, width of the per-entry dwell count.
REQ-004 SHALL have port reference_clk  input  1  sole clock; the block has one clock.
REQ-005 SHALL have port reference_rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port cfg_we  input  1  table write strobe.
REQ-007 SHALL have port cfg_addr  input  $clog2(DEPTH)  table write index.
REQ-008 SHALL have port cfg_wdata  input  2+2*WIDTH+DWELL_W  packed {mode[1:0], freq, punch, dwell}, with mode in the MSBs.
REQ-009 SHALL have port start  input  1  single-cycle pulse that starts the schedule.
REQ-010 SHALL have port stop  input  1  single-cycle pulse that ends the schedule.
REQ-011 SHALL have port mode  output  2  clock-generator mode: 0 ref, 1 divide, 2 punch, 3 random.
REQ-012 SHALL have port freq  output  WIDTH  clock-generator divide/period value.
REQ-013 SHALL have port punch  output  WIDTH  clock-generator punch slot.
REQ-014 SHALL have port busy  output  1  schedule active.
REQ-015 SHALL have port cur_idx  output  $clog2(DEPTH)  entry currently applied.
REQ-016 SHALL have port done  output  1  single-cycle pulse, schedule finished.
REQ-017 SHALL have port cfg_err  output  1  single-cycle pulse, rejected write.

Function
REQ-018 SHALL hold a mirror counter cnt that increments each cycle and wraps to 0 when cnt == freq-1; this boundary condition is "bnd".
REQ-019 SHALL implement a state machine with states IDLE, ALIGN and DWELL.
REQ-020 SHALL drive the idle outputs mode=0, freq=1, punch=0 in IDLE.
REQ-021 SHALL change mode, freq and punch only on a cycle with bnd=1, so that the generator counter never exceeds the new freq-1.
REQ-022 SHALL, on start in IDLE, set idx=0 and enter ALIGN on the next cycle, with busy=1 from that cycle.
REQ-023 SHALL, in ALIGN on bnd, load entry[idx] into the outputs, load dwell into the dwell counter, set cur_idx=idx and enter DWELL.
REQ-024 SHALL treat an entry with dwell==0 as an end marker: on bnd it applies the idle outputs, pulses done, and enters IDLE with busy=0.
REQ-025 SHALL decrement the dwell counter each cycle in DWELL; when the counter reaches 1, it sets idx=idx+1 and enters ALIGN.
REQ-026 SHALL hold an entry's outputs for at least dwell cycles and at most dwell+freq_new-1 cycles.
REQ-027 SHALL, after entry DEPTH-1 expires, perform end handling (see Configuration).
REQ-028 SHALL, on stop in DWELL or ALIGN, set the end flag; the next bnd then applies the idle outputs, pulses done and enters IDLE.
REQ-029 SHALL give stop priority over start when both arrive in the same cycle in IDLE; the block stays in IDLE with no done pulse.
REQ-030 SHALL ignore start while busy.
REQ-031 SHALL write cfg_wdata into entry[cfg_addr] when cfg_we=1 and busy=0.
REQ-032 SHALL drop a write and pulse cfg_err on the next cycle if busy=1, or freq==0, or mode==2 with punch>=freq.

Reset
REQ-033 SHALL on reset set state=IDLE, cnt=0, idx=0, cur_idx=0, dwell counter=0 and end flag=0.
REQ-034 SHALL on reset set the outputs to mode=0, freq=1, punch=0, busy=0, done=0, cfg_err=0.
REQ-035 SHALL on reset clear all table entries to 0, so every entry is an end marker.
REQ-036 SHALL treat reset mid-schedule the same as power-on reset, with no done pulse.

Configuration
REQ-037 SHALL use macro HQM_JG_CLK_SCHED_LOOP_EN: when defined, after entry DEPTH-1 expires, idx wraps to 0 and ALIGN repeats the schedule until stop or an end marker.
REQ-038 SHALL, when HQM_JG_CLK_SCHED_LOOP_EN is undefined, perform end-marker handling (REQ-024) after entry DEPTH-1 expires.

Verification
REQ-039 SHALL pass this scenario: entry0 = {1,4,0,10}, entry1 = end marker, start -> mode=1 and freq=4 at the first bnd, held at least 10 cycles, then mode=0, freq=1 and a done pulse at the next bnd.
REQ-040 SHALL pass this scenario: entry0 = {2,3,1,6}, entry1 = {0,1,0,5}, start -> mode sequence 0,2,0, with each change only on a cycle where cnt==freq-1.
REQ-041 SHALL pass this scenario: write with freq=0, then write mode=2 with punch=5 and freq=4 -> cfg_err pulses twice and the table is unchanged.
REQ-042 SHALL pass this scenario: start and stop in the same cycle in IDLE -> busy stays 0 and done is never pulsed.
REQ-043 SHALL pass this scenario: stop during DWELL of a freq=8 entry -> the idle outputs are applied within 8 cycles and done pulses once.
REQ-044 SHALL pass this scenario: with DEPTH=2, all entries valid and the macro defined -> cur_idx sequence 0,1,0,1; with the macro undefined -> done pulses after entry 1.
